// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - set-associative RV32C instruction cache with combinational hits and line-fill FSM
// Optional feature macro: ICACHE_FENCE_EN (fence_i invalidates all lines).
module icache_assoc #(
  parameter int ADDR_W     = 17,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        stall,
  input  logic        fence_i,
  input  logic        fet_icache_enable,
  input  logic [31:0] fet_pc,
  input  logic        mem_inst_ready,
  input  logic [31:0] mem_inst,
  input  logic [31:0] mem_inst_addr,
  output logic        icache_mem_req,
  output logic [31:0] icache_mem_addr,
  output logic        icache_ready,
  output logic [31:0] icache_inst
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int WORDS = LINE_BYTES / 4;
  localparam int WRD_W = (OFF_W > 2) ? OFF_W - 2 : 1;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_nx;

  logic             valid_mem [WAYS][SETS];
  logic [TAG_W-1:0] tag_mem   [WAYS][SETS];
  logic [31:0]      data_mem  [WAYS][SETS][WORDS];
  logic [WAY_W-1:0] vptr      [SETS];

  logic [WAY_W-1:0]  fill_way;
  logic [IDX_W-1:0]  fill_idx;
  logic [WRD_W-1:0]  cnt;
  logic [ADDR_W-1:0] miss_addr;
  logic              fence_pend;

  function automatic logic [WRD_W-1:0] word_sel(input logic [OFF_W-1:0] off);
    return WRD_W'(off >> 2);
  endfunction

  // Two independent lookups: h0 at pc and h1 at pc+2 (same line or the next one).
  logic [ADDR_W-1:0] pc0, pc1;
  logic [IDX_W-1:0]  idx0, idx1;
  logic [TAG_W-1:0]  tag0, tag1;
  logic [OFF_W-1:0]  off0, off1;
  assign pc0  = fet_pc[ADDR_W-1:0];
  assign pc1  = pc0 + ADDR_W'(2);
  assign off0 = pc0[OFF_W-1:0];
  assign off1 = pc1[OFF_W-1:0];
  assign idx0 = pc0[OFF_W +: IDX_W];
  assign idx1 = pc1[OFF_W +: IDX_W];
  assign tag0 = pc0[ADDR_W-1 -: TAG_W];
  assign tag1 = pc1[ADDR_W-1 -: TAG_W];

  logic             hit0, hit1;
  logic [WAY_W-1:0] way0, way1;
  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    way0 = '0;
    way1 = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_mem[w][idx0] && tag_mem[w][idx0] == tag0) begin
        hit0 = 1'b1;
        way0 = WAY_W'(w);
      end
      if (valid_mem[w][idx1] && tag_mem[w][idx1] == tag1) begin
        hit1 = 1'b1;
        way1 = WAY_W'(w);
      end
    end
  end

  logic [31:0] word0, word1;
  logic [15:0] h0, h1;
  logic        is32, look_ready;
  assign word0      = data_mem[way0][idx0][word_sel(off0)];
  assign word1      = data_mem[way1][idx1][word_sel(off1)];
  assign h0         = off0[1] ? word0[31:16] : word0[15:0];
  assign h1         = off1[1] ? word1[31:16] : word1[15:0];
  assign is32       = (h0[1:0] == 2'b11);
  assign look_ready = hit0 && (!is32 || hit1);

  assign icache_ready    = (state == IDLE) && fet_icache_enable && look_ready;
  assign icache_inst     = !icache_ready ? 32'h0 : (is32 ? {h1, h0} : {16'h0, h0});
  assign icache_mem_req  = (state == FILL);
  assign icache_mem_addr = 32'(miss_addr);

  logic              miss_start;
  logic [ADDR_W-1:0] miss_line;
  logic [IDX_W-1:0]  miss_idx;
  assign miss_start = (state == IDLE) && rdy && fet_icache_enable && !flush && !stall && !look_ready;
  assign miss_line  = hit0 ? {pc1[ADDR_W-1:OFF_W], OFF_W'(0)} : {pc0[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign miss_idx   = miss_line[OFF_W +: IDX_W];

  logic             found;
  logic [WAY_W-1:0] victim;
  always_comb begin
    found  = 1'b0;
    victim = vptr[miss_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_mem[w][miss_idx]) begin
        found  = 1'b1;
        victim = WAY_W'(w);
      end
    end
  end

  logic fill_accept, fill_last, fill_abort;
  assign fill_accept = (state == FILL) && rdy && !flush && !stall && mem_inst_ready;
  assign fill_last   = fill_accept && (cnt == WRD_W'(WORDS - 1));
  assign fill_abort  = (state == FILL) && rdy && flush;

  logic fence_req, inval_all;
`ifdef ICACHE_FENCE_EN
  assign fence_req = fence_i;
`else
  assign fence_req = 1'b0;
  logic unused_fence;
  assign unused_fence = fence_i;
`endif
  // A fence seen during a fill waits for the fill to end, so the new line ends invalid too.
  assign inval_all = rdy && (((state == IDLE) && !stall && fence_req) ||
                             ((fill_abort || fill_last) && (fence_pend || fence_req)));

  logic unused_bits;
  assign unused_bits = ^{fet_pc[31:ADDR_W], mem_inst_addr[31:OFF_W], mem_inst_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (miss_start) state_nx = FILL;
      FILL:    if (fill_abort || fill_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++) valid_mem[w][s] <= 1'b0;
      for (int s = 0; s < SETS; s++) vptr[s] <= '0;
      cnt        <= '0;
      miss_addr  <= '0;
      fill_way   <= '0;
      fill_idx   <= '0;
      fence_pend <= 1'b0;
    end else if (rdy) begin
      if (inval_all)
        for (int w = 0; w < WAYS; w++)
          for (int s = 0; s < SETS; s++) valid_mem[w][s] <= 1'b0;
      if (miss_start) begin
        fill_way  <= victim;
        fill_idx  <= miss_idx;
        miss_addr <= miss_line;
        cnt       <= '0;
        valid_mem[victim][miss_idx] <= 1'b0;
      end
      if ((state == FILL) && fence_req) fence_pend <= 1'b1;
      if (fill_abort) begin
        cnt        <= '0;
        fence_pend <= 1'b0;
      end else if (fill_accept) begin
        if (fill_last) begin
          cnt        <= '0;
          fence_pend <= 1'b0;
          if (!(fence_pend || fence_req)) valid_mem[fill_way][fill_idx] <= 1'b1;
          vptr[fill_idx] <= (vptr[fill_idx] == WAY_W'(WAYS - 1)) ? '0 : vptr[fill_idx] + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && miss_start) tag_mem[victim][miss_idx] <= miss_line[ADDR_W-1 -: TAG_W];
    if (!rst && fill_accept)
      data_mem[fill_way][fill_idx][word_sel(mem_inst_addr[OFF_W-1:0])] <= mem_inst;
  end
endmodule

// File: tb/tb_icache_assoc.sv
// tb/tb_icache_assoc.sv - scoreboard bench for icache_assoc
// Expectations are queued per cycle by the driver and checked by a negedge monitor.
module tb_icache_assoc;
  logic        clk = 1'b0;
  logic        rst, rdy, flush, stall, fence_i, en, mem_ready;
  logic [31:0] pc, mem_inst, mem_addr;
  logic        req, ready;
  logic [31:0] req_addr, inst;

  always #5 clk = ~clk;

  icache_assoc dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .stall(stall), .fence_i(fence_i),
    .fet_icache_enable(en), .fet_pc(pc), .mem_inst_ready(mem_ready), .mem_inst(mem_inst),
    .mem_inst_addr(mem_addr), .icache_mem_req(req), .icache_mem_addr(req_addr),
    .icache_ready(ready), .icache_inst(inst)
  );

  typedef struct {
    string       name;
    logic        e_ready;
    logic [31:0] e_inst;
    logic        e_req;
    logic        chk_addr;
    logic [31:0] e_addr;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    case (a)
      32'h100: return 32'h4501_0513;
      32'h104: return 32'h1111_2222;
      32'h108: return 32'h3333_4444;
      32'h10C: return 32'h0093_1234;
      32'h110: return 32'h5555_00A0;
      default: return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (ready !== e.e_ready || inst !== e.e_inst || req !== e.e_req ||
          (e.chk_addr && req_addr !== e.e_addr)) begin
        bad++;
        $display("FAIL %s: got ready=%b inst=%h req=%b addr=%h, want ready=%b inst=%h req=%b addr=%h",
                 e.name, ready, inst, req, req_addr, e.e_ready, e.e_inst, e.e_req, e.e_addr);
      end
    end
  end

  task automatic push(input string n, input logic r, input logic [31:0] i,
                      input logic q, input logic ca, input logic [31:0] a);
    exp_t e;
    e.name = n; e.e_ready = r; e.e_inst = i; e.e_req = q; e.chk_addr = ca; e.e_addr = a;
    sb.push_back(e);
  endtask

  task automatic cyc(input string n, input logic r, input logic [31:0] i,
                     input logic q, input logic [31:0] a);
    push(n, r, i, q, q, a);
    @(posedge clk); #1;
  endtask

  task automatic feed(input logic [31:0] base, input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      mem_ready = 1'b1;
      mem_addr  = base + 32'(4 * k);
      mem_inst  = memw(base + 32'(4 * k));
      cyc($sformatf("fill_%0h_w%0d", base, k), 1'b0, 32'h0, 1'b1, base);
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; stall = 1'b0; fence_i = 1'b0; en = 1'b0;
    mem_ready = 1'b0; pc = 32'h0; mem_inst = 32'h0; mem_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    push("reset", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    en = 1'b1; pc = 32'h100;
    cyc("miss_100", 1'b0, 32'h0, 1'b0, 32'h0);
    feed(32'h100, 0, 4);
    cyc("hit_100", 1'b1, 32'h4501_0513, 1'b0, 32'h0);
    pc = 32'h102;
    cyc("c16_102", 1'b1, 32'h0000_4501, 1'b0, 32'h0);

    pc = 32'h10E;
    cyc("straddle_miss", 1'b0, 32'h0, 1'b0, 32'h0);
    feed(32'h110, 0, 4);
    cyc("straddle_hit", 1'b1, 32'h00A0_0093, 1'b0, 32'h0);

    pc = 32'h300; flush = 1'b1;
    cyc("flush_idle", 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("flush_idle_noreq", 1'b0, 32'h0, 1'b0, 32'h0);
    flush = 1'b0; rdy = 1'b0;
    cyc("rdy0", 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("rdy0_noreq", 1'b0, 32'h0, 1'b0, 32'h0);
    rdy = 1'b1; pc = 32'h100;
    cyc("hit_100_again", 1'b1, 32'h4501_0513, 1'b0, 32'h0);

    pc = 32'h500;
    cyc("miss_500", 1'b0, 32'h0, 1'b0, 32'h0);
    feed(32'h500, 0, 4);
    cyc("hit_500", 1'b1, 32'h0500_FAFF, 1'b0, 32'h0);
    pc = 32'h900;
    cyc("miss_900", 1'b0, 32'h0, 1'b0, 32'h0);
    feed(32'h900, 0, 4);
    cyc("hit_900", 1'b1, 32'h0900_F6FF, 1'b0, 32'h0);
    pc = 32'h500;
    cyc("kept_500", 1'b1, 32'h0500_FAFF, 1'b0, 32'h0);
    pc = 32'h100;
    cyc("evicted_100", 1'b0, 32'h0, 1'b0, 32'h0);

    feed(32'h100, 0, 2);
    flush = 1'b1;
    cyc("flush_fill", 1'b0, 32'h0, 1'b1, 32'h100);
    flush = 1'b0;
    cyc("after_flush", 1'b0, 32'h0, 1'b0, 32'h0);
    feed(32'h100, 0, 1);
    stall = 1'b1; mem_ready = 1'b1; mem_addr = 32'h100; mem_inst = 32'hDEAD_BEEF;
    cyc("stall_drop", 1'b0, 32'h0, 1'b1, 32'h100);
    stall = 1'b0; mem_ready = 1'b0;
    feed(32'h100, 1, 3);
    cyc("refill_hit", 1'b1, 32'h4501_0513, 1'b0, 32'h0);

    fence_i = 1'b1;
    cyc("fence_cyc", 1'b1, 32'h4501_0513, 1'b0, 32'h0);
    fence_i = 1'b0;
`ifdef ICACHE_FENCE_EN
    cyc("after_fence", 1'b0, 32'h0, 1'b0, 32'h0);
`else
    cyc("after_fence", 1'b1, 32'h4501_0513, 1'b0, 32'h0);
`endif

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
